bus_master_port: RTL and testbench



---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_shift_reg.sv | 29 ++
 rtl/bus_master_port.sv | 180 ++++++++++++++++++
 tb/tb_bus_master_port.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and defaults for the serial system bus
// Used by the master port, slave ports and arbiter.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_ACK_WAIT,
    ST_WDATA,
    ST_RDATA
  } bus_state_e;

endpackage

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - parallel-load register shifting right, LSB out / serial in at MSB
// One shift serves both directions: bit 0 leaves while sin_i enters at the top.
module bus_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= din_i;
    end else if (shift_i) begin
      data_q <= {sin_i, data_q[WIDTH-1:1]};
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side serial bus port for the UART bus bridge
// Takes one parallel transaction, arbitrates, shifts address/data serially, returns status.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  sready,
  input  logic                  svalid,
  input  logic                  mrdata
);

  localparam int SR_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BIT_W = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  bus_state_e            state_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] drdata_q;
  logic                  ddone_q;
  logic                  derr_q;

  logic                  sr_load;
  logic                  sr_shift;
  logic                  sr_sin;
  logic [SR_W-1:0]       sr_d;
  logic [SR_W-1:0]       sr_q;
  logic [SR_W-1:0]       sr_shifted;

  // The single shift register holds the address first, then write data or incoming read bits.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_sin   = 1'b0;
    sr_d     = SR_W'(daddr);
    case (state_q)
      ST_IDLE:          sr_load = dvalid;
      ST_ADDR, ST_WDATA: sr_shift = 1'b1;
      ST_ACK_WAIT: begin
        sr_d    = SR_W'(wdata_q);
        sr_load = sready && (mode_q == MODE_WRITE);
      end
      ST_RDATA: begin
        sr_shift = svalid;
        sr_sin   = mrdata;
      end
      default: ;
    endcase
  end

  bus_shift_reg #(
    .WIDTH(SR_W)
  ) u_shift (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (sr_load),
    .shift_i(sr_shift),
    .sin_i  (sr_sin),
    .din_i  (sr_d),
    .q_o    (sr_q)
  );

  // Read bits land at the top of the register; the final bit is folded in as it arrives.
  assign sr_shifted = {mrdata, sr_q[SR_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      mode_q    <= 1'b0;
      wdata_q   <= '0;
      drdata_q  <= '0;
      ddone_q   <= 1'b0;
      derr_q    <= 1'b0;
    end else begin
      ddone_q <= 1'b0;
      derr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dvalid) begin
            mode_q    <= dmode;
            wdata_q   <= dwdata;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mbgrant) begin
            bit_cnt_q <= '0;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bit_cnt_q == ADDR_LAST) begin
            tmo_cnt_q <= '0;
            state_q   <= ST_ACK_WAIT;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        ST_ACK_WAIT: begin
          if (sready) begin
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            state_q   <= (mode_q == MODE_READ) ? ST_RDATA : ST_WDATA;
          end else if (tmo_cnt_q == TMO_LAST) begin
            ddone_q <= 1'b1;
            derr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_WDATA: begin
          if (bit_cnt_q == DATA_LAST) begin
            ddone_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        ST_RDATA: begin
          if (svalid) begin
            tmo_cnt_q <= '0;
            if (bit_cnt_q == DATA_LAST) begin
              drdata_q <= sr_shifted[SR_W-1 -: DATA_WIDTH];
              ddone_q  <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            ddone_q <= 1'b1;
            derr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dready = (state_q == ST_IDLE);
  assign mbreq  = (state_q != ST_IDLE);
  assign mvalid = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign mwdata = mvalid & sr_q[0];
  assign mmode  = mode_q;
  assign drdata = drdata_q;
  assign ddone  = ddone_q;
  assign derr   = derr_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - directed self-checking bench for bus_master_port
module tb_bus_master_port;

  logic        clk;
  logic        rst;
  logic        dvalid;
  logic        dready;
  logic        dmode;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic [7:0]  drdata;
  logic        ddone;
  logic        derr;
  logic        mbreq;
  logic        mbgrant;
  logic        mwdata;
  logic        mmode;
  logic        mvalid;
  logic        sready;
  logic        svalid;
  logic        mrdata;

  int n_tests = 0;
  int n_fail  = 0;

  bus_master_port #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .TIMEOUT   (64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dvalid (dvalid),
    .dready (dready),
    .dmode  (dmode),
    .daddr  (daddr),
    .dwdata (dwdata),
    .drdata (drdata),
    .ddone  (ddone),
    .derr   (derr),
    .mbreq  (mbreq),
    .mbgrant(mbgrant),
    .mwdata (mwdata),
    .mmode  (mmode),
    .mvalid (mvalid),
    .sready (sready),
    .svalid (svalid),
    .mrdata (mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_txn(input logic m, input logic [15:0] a, input logic [7:0] w);
    dvalid = 1'b1;
    dmode  = m;
    daddr  = a;
    dwdata = w;
    tick();
    dvalid = 1'b0;
  endtask

  // Holds grant low for n REQ cycles, then raises it for exactly one cycle.
  task automatic grant_after(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (mbreq !== 1'b1 || dready !== 1'b0 || mvalid !== 1'b0) bad++;
      tick();
    end
    if (mbreq !== 1'b1) bad++;
    mbgrant = 1'b1;
    tick();
    mbgrant = 1'b0;
    check("req_phase", 32'(bad), 32'd0);
  endtask

  task automatic shift_addr(input logic [15:0] exp, input logic m);
    logic [15:0] g;
    int bad;
    bad = 0;
    g   = '0;
    for (int i = 0; i < 16; i++) begin
      g[i] = mwdata;
      if (mvalid !== 1'b1 || mmode !== m || mbreq !== 1'b1 || ddone !== 1'b0) bad++;
      tick();
    end
    check("addr_bits", 32'(g), 32'(exp));
    check("addr_ctl", 32'(bad), 32'd0);
    check("ackwait_mvalid", 32'(mvalid), 32'd0);
  endtask

  task automatic shift_wdata(input logic [7:0] exp);
    logic [7:0] g;
    int bad;
    bad = 0;
    g   = '0;
    for (int i = 0; i < 8; i++) begin
      g[i] = mwdata;
      if (mvalid !== 1'b1 || mmode !== 1'b1 || ddone !== 1'b0 || mbreq !== 1'b1) bad++;
      tick();
    end
    check("wdata_bits", 32'(g), 32'(exp));
    check("wdata_ctl", 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] rd_val;
    int         gaps[8];
    int         bad;

    rst     = 1'b1;
    dvalid  = 1'b0;
    dmode   = 1'b0;
    daddr   = '0;
    dwdata  = '0;
    mbgrant = 1'b0;
    sready  = 1'b0;
    svalid  = 1'b0;
    mrdata  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_dready", 32'(dready), 32'd1);
    check("rst_mbreq",  32'(mbreq),  32'd0);
    check("rst_mvalid", 32'(mvalid), 32'd0);
    check("rst_mwdata", 32'(mwdata), 32'd0);
    check("rst_mmode",  32'(mmode),  32'd0);
    check("rst_ddone",  32'(ddone),  32'd0);
    check("rst_derr",   32'(derr),   32'd0);
    check("rst_drdata", 32'(drdata), 32'd0);

    // Write 0x01A5 / 0x3C, grant after 3 cycles, sready 2 cycles into ACK_WAIT
    start_txn(1'b1, 16'h01A5, 8'h3C);
    check("w_mbreq_t1", 32'(mbreq), 32'd1);
    grant_after(3);
    shift_addr(16'h01A5, 1'b1);
    tick();
    tick();
    sready = 1'b1;
    tick();
    sready = 1'b0;
    shift_wdata(8'h3C);
    check("w_ddone",  32'(ddone),  32'd1);
    check("w_derr",   32'(derr),   32'd0);
    check("w_dready", 32'(dready), 32'd1);
    tick();
    check("w_mbreq_after", 32'(mbreq), 32'd0);
    check("w_ddone_once",  32'(ddone), 32'd0);

    // Read 0x1003, slave returns 0xA5 with svalid gaps
    rd_val = 8'hA5;
    gaps   = '{0, 1, 3, 0, 1, 3, 0, 1};
    start_txn(1'b0, 16'h1003, 8'h00);
    grant_after(0);
    shift_addr(16'h1003, 1'b0);
    sready = 1'b1;
    tick();
    sready = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        if (ddone !== 1'b0 || drdata !== 8'h00 || mvalid !== 1'b0) bad++;
        tick();
      end
      svalid = 1'b1;
      mrdata = rd_val[i];
      if (ddone !== 1'b0 || drdata !== 8'h00) bad++;
      tick();
      svalid = 1'b0;
    end
    check("r_early", 32'(bad), 32'd0);
    check("r_ddone",  32'(ddone),  32'd1);
    check("r_derr",   32'(derr),   32'd0);
    check("r_drdata", 32'(drdata), 32'hA5);
    tick();
    check("r_ddone_once", 32'(ddone),  32'd0);
    check("r_drdata_hold", 32'(drdata), 32'hA5);

    // sready never arrives: abort exactly TIMEOUT cycles after ACK_WAIT entry
    start_txn(1'b0, 16'h1FFF, 8'h00);
    grant_after(1);
    shift_addr(16'h1FFF, 1'b0);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (ddone !== 1'b0 || derr !== 1'b0 || dready !== 1'b0 || mbreq !== 1'b1) bad++;
      tick();
    end
    check("to_early", 32'(bad), 32'd0);
    check("to_ddone",  32'(ddone),  32'd1);
    check("to_derr",   32'(derr),   32'd1);
    check("to_dready", 32'(dready), 32'd1);
    check("to_drdata", 32'(drdata), 32'hA5);
    tick();
    check("to_derr_once", 32'(derr), 32'd0);

    // dvalid held high with changing inputs: only the first capture is used
    dvalid = 1'b1;
    dmode  = 1'b1;
    daddr  = 16'h0055;
    dwdata = 8'h81;
    tick();
    daddr  = 16'h0777;
    dmode  = 1'b0;
    dwdata = 8'hEE;
    grant_after(0);
    shift_addr(16'h0055, 1'b1);
    sready = 1'b1;
    tick();
    sready = 1'b0;
    shift_wdata(8'h81);
    check("hold_ddone",  32'(ddone),  32'd1);
    check("hold_dready", 32'(dready), 32'd1);
    tick();
    dvalid = 1'b0;
    check("hold_recapture_mbreq",  32'(mbreq),  32'd1);
    check("hold_recapture_dready", 32'(dready), 32'd0);
    grant_after(0);
    shift_addr(16'h0777, 1'b0);
    sready = 1'b1;
    tick();
    sready = 1'b0;
    rd_val = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1;
      mrdata = rd_val[i];
      tick();
    end
    svalid = 1'b0;
    check("hold_r_ddone",  32'(ddone),  32'd1);
    check("hold_r_drdata", 32'(drdata), 32'h3C);
    tick();

    // Reset during write data bit 3
    start_txn(1'b1, 16'h0F0F, 8'h5A);
    grant_after(0);
    shift_addr(16'h0F0F, 1'b1);
    sready = 1'b1;
    tick();
    sready = 1'b0;
    repeat (3) tick();
    check("rst_mid_bit3", 32'(mwdata), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_mbreq",  32'(mbreq),  32'd0);
    check("rst_mid_mvalid", 32'(mvalid), 32'd0);
    check("rst_mid_dready", 32'(dready), 32'd1);
    check("rst_mid_ddone",  32'(ddone),  32'd0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (ddone !== 1'b0 || mbreq !== 1'b0) bad++;
      tick();
    end
    check("rst_mid_quiet", 32'(bad), 32'd0);

    // Grant withheld for 500 cycles
    start_txn(1'b1, 16'h0001, 8'h01);
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      if (mbreq !== 1'b1 || derr !== 1'b0 || ddone !== 1'b0 || dready !== 1'b0 || mvalid !== 1'b0) bad++;
      tick();
    end
    check("nogrant_hold", 32'(bad), 32'd0);
    check("nogrant_mbreq", 32'(mbreq), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
